reg_file_2r1w: RTL
==================

Name: reg_file_2r1w

Overview:
Parametrised register file, successor to the fixed 32-input, 32-bit select mux. Holds DEPTH words of WIDTH bits, with one synchronous write port and two independent registered read ports (A, B). Includes write-to-read bypass and an optional hardwired-zero register 0. Sits in the datapath between decode (addresses) and the ALU operand latches.

Parameters:
WIDTH, 32, data word width in bits (1..64)
DEPTH, 32, number of registers (2..64; need not be a power of 2)
AW, 5, address width; must satisfy 2**AW >= DEPTH
ZERO_R0, 1, 1 = register 0 always reads 0 and ignores writes; 0 = register 0 is an ordinary register

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous active-high reset
we  input  1  write enable
waddr  input  AW  write address
wdata  input  WIDTH  write data
re_a  input  1  read request, port A
raddr_a  input  AW  read address, port A
rdata_a  output  WIDTH  registered read data, port A
rvalid_a  output  1  port A data valid (one-cycle pulse per request)
re_b  input  1  read request, port B
raddr_b  input  AW  read address, port B
rdata_b  output  WIDTH  registered read data, port B
rvalid_b  output  1  port B data valid

Behaviour:
- One clock; reset is synchronous and active-high. Every action occurs only on the rising edge of clk.
- Reset: all DEPTH registers clear to 0; rdata_a = rdata_b = 0; rvalid_a = rvalid_b = 0. Reset has priority over a same-cycle write or read.
- A write mid-operation with reset high is discarded. A read request issued in the reset cycle produces no rvalid.
- Write: if we=1, waddr < DEPTH, and not (ZERO_R0=1 and waddr=0), then mem[waddr] <= wdata at the edge. Otherwise memory is unchanged.
- Read latency: 1 cycle. If re_x=1 at edge N, then rdata_x holds the result and rvalid_x=1 during cycle N+1. If re_x=0 at edge N, rvalid_x=0 in N+1 and rdata_x holds its previous value (no bubble to 0).
- Read result priority per port:
  1. raddr_x >= DEPTH -> 0
  2. ZERO_R0=1 and raddr_x=0 -> 0
  3. Bypass: we=1 and waddr=raddr_x (and the write is legal) -> wdata, i.e. the new value, not the stale one
  4. otherwise mem[raddr_x]
- Ports A and B are fully independent. They may read the same address in the same cycle, and both may bypass from the same write.
- Back-to-back reads every cycle are supported, giving a throughput of 1 read per port per cycle.
- No internal state machine beyond the per-port output register and valid flag. The storage array plus the two read pipelines are the sequential state.
- rvalid_x depends only on re_x and reset, never on address legality. An out-of-range read still returns valid=1 with data 0.
- Memory contents persist indefinitely without re-writes. No read side effects.

Test Plan:
- Reset then read all 32 addresses on both ports -> rdata=0x00000000 with rvalid=1 one cycle after each request; rvalid=0 during reset and on the first cycle after it if re=0.
- Write 0xDEADBEEF to addr 5, then read A@5 and B@5 the next cycle -> both rdata=0xDEADBEEF one cycle later. Write 0x1234 to addr 0 with ZERO_R0=1, read A@0 -> 0x00000000.
- Same-cycle bypass: mem[7]=0x11111111; assert we, waddr=7, wdata=0x22222222, re_a with raddr_a=7 -> rdata_a=0x22222222 next cycle; a subsequent read of 7 also gives 0x22222222.
- Hold behaviour: read A@3 (mem=0xA5A5A5A5), then re_a=0 for 3 cycles while writing addr 3=0x0 -> rdata_a stays 0xA5A5A5A5 and rvalid_a=0 after the first pulse.
- Reset mid-operation: write 0xCAFEF00D to addr 9, then assert reset together with we (addr 9=0xFFFFFFFF) and re_a@9 -> next cycle rvalid_a=0, rdata_a=0; a later read of 9 returns 0x00000000.
- Instance with DEPTH=24, WIDTH=16, AW=5: write 0xBEEF to addr 30, read A@30 and B@23 (pre-written 0x00FF) -> rdata_a=0x0000 with rvalid_a=1, rdata_b=0x00FF.

Source files
------------

// File: rtl/reg_file_2r1w_if.sv
// -----------------------------------------------------------------------------
// reg_file_2r1w_if
// Bus bundle for the 2-read / 1-write register file.
//   write port : we, waddr, wdata
//   read port A: re_a, raddr_a -> rdata_a, rvalid_a
//   read port B: re_b, raddr_b -> rdata_b, rvalid_b
// master = decode side (drives requests), slave = register file.
// -----------------------------------------------------------------------------
interface reg_file_2r1w_if #(
   parameter int WIDTH = 32,
   parameter int AW    = 5
);
   logic             we;
   logic [AW-1:0]    waddr;
   logic [WIDTH-1:0] wdata;
   logic             re_a;
   logic [AW-1:0]    raddr_a;
   logic [WIDTH-1:0] rdata_a;
   logic             rvalid_a;
   logic             re_b;
   logic [AW-1:0]    raddr_b;
   logic [WIDTH-1:0] rdata_b;
   logic             rvalid_b;

   modport master (
      output we, waddr, wdata, re_a, raddr_a, re_b, raddr_b,
      input  rdata_a, rvalid_a, rdata_b, rvalid_b
   );

   modport slave (
      input  we, waddr, wdata, re_a, raddr_a, re_b, raddr_b,
      output rdata_a, rvalid_a, rdata_b, rvalid_b
   );
endinterface

// File: rtl/reg_file_2r1w.sv
// -----------------------------------------------------------------------------
// reg_file_2r1w
// DEPTH x WIDTH register file with one synchronous write port and two
// independent registered read ports. Read latency is one cycle; a read that
// hits the address being written in the same cycle returns the new data.
// Optionally register 0 is hardwired to zero.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; clears storage and both read pipelines
//   rf    : reg_file_2r1w_if.slave (write port, read ports A and B)
// -----------------------------------------------------------------------------
module reg_file_2r1w #(
   parameter int WIDTH   = 32,
   parameter int DEPTH   = 32,
   parameter int AW      = 5,
   parameter int ZERO_R0 = 1
) (
   input logic             clk,
   input logic             reset,
   reg_file_2r1w_if.slave  rf
);

   // One extra bit so DEPTH == 2**AW is representable.
   localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];

   logic [WIDTH-1:0] mem [DEPTH];

   logic             wr_ok;
   logic [WIDTH-1:0] rd_a;
   logic [WIDTH-1:0] rd_b;

   logic [WIDTH-1:0] rdata_a_p1;
   logic [WIDTH-1:0] rdata_b_p1;
   logic             vld_a_p1;
   logic             vld_b_p1;

   // Read-result priority: out of range, then hardwired zero, then bypass of
   // the same-cycle write, then stored word. The stored word is only
   // meaningful when the address is in range, which the first test ensures.
   function automatic logic [WIDTH-1:0] resolve(
      input logic [AW-1:0]    ra,
      input logic [WIDTH-1:0] stored,
      input logic             wok,
      input logic [AW-1:0]    wa,
      input logic [WIDTH-1:0] wd
   );
      if ({1'b0, ra} >= DEPTH_L)
         return '0;
      if ((ZERO_R0 != 0) && (ra == '0))
         return '0;
      if (wok && (wa == ra))
         return wd;
      return stored;
   endfunction

   always_comb begin
      wr_ok = rf.we && ({1'b0, rf.waddr} < DEPTH_L)
              && !((ZERO_R0 != 0) && (rf.waddr == '0));
   end

   always_comb begin
      rd_a = resolve(rf.raddr_a, mem[rf.raddr_a], wr_ok, rf.waddr, rf.wdata);
      rd_b = resolve(rf.raddr_b, mem[rf.raddr_b], wr_ok, rf.waddr, rf.wdata);
   end

   // ---- stage p1: storage update and registered read outputs ----
   always_ff @(posedge clk) begin
      if (reset) begin
         mem        <= '{default: '0};
         rdata_a_p1 <= '0;
         rdata_b_p1 <= '0;
         vld_a_p1   <= 1'b0;
         vld_b_p1   <= 1'b0;
      end else begin
         if (wr_ok)
            mem[rf.waddr] <= rf.wdata;
         vld_a_p1 <= rf.re_a;
         vld_b_p1 <= rf.re_b;
         // Without a request the output holds its last value.
         if (rf.re_a)
            rdata_a_p1 <= rd_a;
         if (rf.re_b)
            rdata_b_p1 <= rd_b;
      end
   end

   assign rf.rdata_a  = rdata_a_p1;
   assign rf.rvalid_a = vld_a_p1;
   assign rf.rdata_b  = rdata_b_p1;
   assign rf.rvalid_b = vld_b_p1;

endmodule
